// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for a sync-write/async-read data memory: port 0 = core LSU, port 1 = loader/DMA.
// Build option DMEM_ARB_ROUND_ROBIN_EN: round-robin tie break (default: port 0 wins ties).
module data_mem_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // port 0: core load/store unit
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic              p0_lock_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [WIDTH-1:0]  p0_wdata_i,
  output logic              p0_gnt_o,
  output logic              p0_rvalid_o,
  output logic [WIDTH-1:0]  p0_rdata_o,
  // port 1: loader / DMA
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic              p1_lock_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [WIDTH-1:0]  p1_wdata_i,
  output logic              p1_gnt_o,
  output logic              p1_rvalid_o,
  output logic [WIDTH-1:0]  p1_rdata_o,
  // memory side
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WIDTH-1:0]  mem_wd_o,
  input  logic [WIDTH-1:0]  mem_rd_i
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [WIDTH-1:0]   wd_q;
  logic               p0_rvalid_q, p1_rvalid_q;
  logic [WIDTH-1:0]   p0_rdata_q, p1_rdata_q;

  logic               tie_to_p1_c;
  logic               arb0_c, arb1_c;
  logic               gnt0_c, gnt1_c;
  logic               forced_c;
  logic               burst_full_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic               rd0_c, rd1_c;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic               last_q;

  // Tie goes to the port that was not granted last.
  always_comb tie_to_p1_c = ~last_q;
`else
  always_comb tie_to_p1_c = 1'b0;
`endif

  // Plain arbitration used whenever no owner holds the memory.
  always_comb begin
    arb0_c = p0_req_i & ~(p1_req_i & tie_to_p1_c);
    arb1_c = p1_req_i & ~(p0_req_i & ~tie_to_p1_c);
  end

  always_comb begin
    burst_full_c = (cnt_q >= CNT_W'(MAX_BURST));
    cnt_inc_c    = burst_full_c ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Grant selection: a requesting owner keeps the memory until its burst budget runs out.
  always_comb begin
    gnt0_c   = 1'b0;
    gnt1_c   = 1'b0;
    forced_c = 1'b0;
    unique case (state_q)
      ST_OWN0: begin
        if (p0_req_i) begin
          if (burst_full_c && p1_req_i) begin
            gnt1_c   = 1'b1;
            forced_c = 1'b1;
          end else begin
            gnt0_c = 1'b1;
          end
        end else begin
          gnt0_c = arb0_c;
          gnt1_c = arb1_c;
        end
      end
      ST_OWN1: begin
        if (p1_req_i) begin
          if (burst_full_c && p0_req_i) begin
            gnt0_c   = 1'b1;
            forced_c = 1'b1;
          end else begin
            gnt1_c = 1'b1;
          end
        end else begin
          gnt0_c = arb0_c;
          gnt1_c = arb1_c;
        end
      end
      default: begin
        gnt0_c = arb0_c;
        gnt1_c = arb1_c;
      end
    endcase
    if (rst_i) begin
      gnt0_c   = 1'b0;
      gnt1_c   = 1'b0;
      forced_c = 1'b0;
    end
  end

  // Ownership follows a locked grant; a forced hand-over always returns to IDLE.
  always_comb begin
    state_d = ST_IDLE;
    cnt_d   = '0;
    if (gnt0_c && !forced_c && p0_lock_i) begin
      state_d = ST_OWN0;
      cnt_d   = (state_q == ST_OWN0) ? cnt_inc_c : CNT_W'(1);
    end else if (gnt1_c && !forced_c && p1_lock_i) begin
      state_d = ST_OWN1;
      cnt_d   = (state_q == ST_OWN1) ? cnt_inc_c : CNT_W'(1);
    end
  end

  // Memory drive: granted port's request, otherwise hold the last address/data with WE low.
  always_comb begin
    mem_we_o   = 1'b0;
    mem_addr_o = addr_q;
    mem_wd_o   = wd_q;
    if (gnt0_c) begin
      mem_we_o   = p0_we_i;
      mem_addr_o = p0_addr_i;
      mem_wd_o   = p0_wdata_i;
    end else if (gnt1_c) begin
      mem_we_o   = p1_we_i;
      mem_addr_o = p1_addr_i;
      mem_wd_o   = p1_wdata_i;
    end
  end

  always_comb begin
    rd0_c = gnt0_c & ~p0_we_i;
    rd1_c = gnt1_c & ~p1_we_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wd_q        <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p0_rvalid_q <= rd0_c;
      p1_rvalid_q <= rd1_c;
      if (rd0_c) begin
        p0_rdata_q <= mem_rd_i;
      end
      if (rd1_c) begin
        p1_rdata_q <= mem_rd_i;
      end
      if (gnt0_c || gnt1_c) begin
        addr_q <= mem_addr_o;
        wd_q   <= mem_wd_o;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        last_q <= gnt1_c;
`endif
      end
    end
  end

  assign p0_gnt_o    = gnt0_c;
  assign p1_gnt_o    = gnt1_c;
  assign p0_rvalid_o = p0_rvalid_q;
  assign p1_rvalid_o = p1_rvalid_q;
  assign p0_rdata_o  = p0_rdata_q;
  assign p1_rdata_o  = p1_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus a randomized run
// against a rule-level reference model. Honours DMEM_ARB_ROUND_ROBIN_EN.
module tb_data_mem_arbiter;

  localparam int WIDTH     = 32;
  localparam int ADDR_W    = 32;
  localparam int MAX_BURST = 4;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
  logic [ADDR_W-1:0] p0_addr;
  logic [WIDTH-1:0]  p0_wdata, p0_rdata;
  logic              p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
  logic [ADDR_W-1:0] p1_addr;
  logic [WIDTH-1:0]  p1_wdata, p1_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wd, mem_rd;

  logic [WIDTH-1:0]  mem     [16];
  logic [WIDTH-1:0]  ref_mem [16];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
    .clk_i(clk), .rst_i(rst),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_lock_i(p0_lock), .p0_addr_i(p0_addr),
    .p0_wdata_i(p0_wdata), .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_lock_i(p1_lock), .p1_addr_i(p1_addr),
    .p1_wdata_i(p1_wdata), .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
  );

  // Memory model: synchronous write, asynchronous read.
  always @(posedge clk) if (mem_we) mem[mem_addr[3:0]] <= mem_wd;
  assign mem_rd = mem[mem_addr[3:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p0_req = 1'b0; p0_we = 1'b0; p0_lock = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_lock = 1'b0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 2; p0_wdata = 32'h1111_2222;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 3; p1_wdata = 32'h3333_4444;
    @(negedge clk);
    tests++; if (p0_gnt !== 1'b0) begin fails++; $display("FAIL reset_p0_gnt: got %b want 0", p0_gnt); end
    tests++; if (p1_gnt !== 1'b0) begin fails++; $display("FAIL reset_p1_gnt: got %b want 0", p1_gnt); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    tick();
    idle_inputs();
    tick();
    rst = 1'b0;
    @(negedge clk);
    tests++; if (p0_rvalid !== 1'b0) begin fails++; $display("FAIL reset_p0_rvalid: got %b want 0", p0_rvalid); end
    tests++; if (p1_rvalid !== 1'b0) begin fails++; $display("FAIL reset_p1_rvalid: got %b want 0", p1_rvalid); end
    tests++; if (p0_rdata !== '0) begin fails++; $display("FAIL reset_p0_rdata: got %h want 0", p0_rdata); end
    tests++; if (p1_rdata !== '0) begin fails++; $display("FAIL reset_p1_rdata: got %h want 0", p1_rdata); end
    tick();
  endtask

  task automatic test_fill();
    do_reset();
    for (int a = 0; a < 16; a++) begin
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = a; p0_wdata = $urandom;
      @(negedge clk);
      tests++; if (p0_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'(a)) begin
        fails++; $display("FAIL fill_%0d: got gnt=%b we=%b addr=%h want 1 1 %h", a, p0_gnt, mem_we, mem_addr, a);
      end
      ref_mem[a] = p0_wdata;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_rw();
    do_reset();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 5; p0_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    tests++; if (p0_gnt !== 1'b1) begin fails++; $display("FAIL rw_wr_gnt: got %b want 1", p0_gnt); end
    tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL rw_wr_we: got %b want 1", mem_we); end
    tests++; if (mem_addr !== 32'd5 || mem_wd !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL rw_wr_bus: got addr=%h wd=%h want 5 deadbeef", mem_addr, mem_wd);
    end
    tick();
    ref_mem[5] = 32'hDEAD_BEEF;
    p0_we = 1'b0;
    @(negedge clk);
    tests++; if (p0_gnt !== 1'b1) begin fails++; $display("FAIL rw_rd_gnt: got %b want 1", p0_gnt); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rw_rd_we: got %b want 0", mem_we); end
    tests++; if (p0_rvalid !== 1'b0) begin fails++; $display("FAIL rw_wr_no_rvalid: got %b want 0", p0_rvalid); end
    tick();
    idle_inputs();
    @(negedge clk);
    tests++; if (p0_rvalid !== 1'b1) begin fails++; $display("FAIL rw_rvalid: got %b want 1", p0_rvalid); end
    tests++; if (p0_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rw_rdata: got %h want deadbeef", p0_rdata); end
    tests++; if (p1_rvalid !== 1'b0) begin fails++; $display("FAIL rw_p1_rvalid: got %b want 0", p1_rvalid); end
    tick();
    @(negedge clk);
    tests++; if (p0_rvalid !== 1'b0) begin fails++; $display("FAIL rw_rvalid_pulse: got %b want 0", p0_rvalid); end
    tests++; if (p0_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rw_rdata_hold: got %h want deadbeef", p0_rdata); end
    tick();
  endtask

  task automatic test_tie();
    bit e0, e1, prev0, prev1;
    do_reset();
    p0_req = 1'b1; p0_addr = 1;
    p1_req = 1'b1; p1_addr = 2;
    prev0 = 1'b0; prev1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      e0 = RR ? (k % 2 == 0) : 1'b1;
      e1 = ~e0;
      @(negedge clk);
      tests++; if (p0_gnt !== e0 || p1_gnt !== e1) begin
        fails++; $display("FAIL tie_gnt_%0d: got %b%b want %b%b", k, p0_gnt, p1_gnt, e0, e1);
      end
      tests++; if (p0_rvalid !== prev0 || p1_rvalid !== prev1) begin
        fails++; $display("FAIL tie_rvalid_%0d: got %b%b want %b%b", k, p0_rvalid, p1_rvalid, prev0, prev1);
      end
      if (prev0) begin
        tests++; if (p0_rdata !== ref_mem[1]) begin fails++; $display("FAIL tie_p0_rdata_%0d: got %h want %h", k, p0_rdata, ref_mem[1]); end
      end
      if (prev1) begin
        tests++; if (p1_rdata !== ref_mem[2]) begin fails++; $display("FAIL tie_p1_rdata_%0d: got %h want %h", k, p1_rdata, ref_mem[2]); end
      end
      prev0 = e0; prev1 = e1;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_burst();
    bit e0;
    do_reset();
    p1_req = 1'b1; p1_lock = 1'b1; p1_addr = 4;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) begin p0_req = 1'b1; p0_addr = 6; end
      if (k < 4) e0 = 1'b0;
      else if (k == 4) e0 = 1'b1;
      else e0 = ~RR;
      @(negedge clk);
      tests++; if (p0_gnt !== e0 || p1_gnt !== ~e0) begin
        fails++; $display("FAIL burst_gnt_%0d: got %b%b want %b%b", k, p0_gnt, p1_gnt, e0, ~e0);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_same_addr();
    do_reset();
    p1_req = 1'b1; p1_lock = 1'b1; p1_we = 1'b1; p1_addr = 3; p1_wdata = 32'hA5A5_0003;
    @(negedge clk);
    tests++; if (p1_gnt !== 1'b1) begin fails++; $display("FAIL same_own_gnt: got %b want 1", p1_gnt); end
    tick();
    ref_mem[3] = 32'hA5A5_0003;
    p1_lock = 1'b0; p1_addr = 9; p1_wdata = 32'h0000_1234;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9;
    @(negedge clk);
    tests++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin
      fails++; $display("FAIL same_wr_gnt: got p0=%b p1=%b want 0 1", p0_gnt, p1_gnt);
    end
    tests++; if (mem_we !== 1'b1 || mem_addr !== 32'd9) begin
      fails++; $display("FAIL same_wr_bus: got we=%b addr=%h want 1 9", mem_we, mem_addr);
    end
    tick();
    ref_mem[9] = 32'h0000_1234;
    p1_req = 1'b0; p1_we = 1'b0;
    @(negedge clk);
    tests++; if (p0_gnt !== 1'b1) begin fails++; $display("FAIL same_rd_gnt: got %b want 1", p0_gnt); end
    tick();
    p0_req = 1'b0;
    @(negedge clk);
    tests++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h0000_1234) begin
      fails++; $display("FAIL same_rd_data: got v=%b d=%h want 1 00001234", p0_rvalid, p0_rdata);
    end
    tick();
  endtask

  task automatic test_rst_mid();
    do_reset();
    p0_req = 1'b1; p0_addr = 5;
    p1_req = 1'b1; p1_lock = 1'b1; p1_addr = 5;
    @(negedge clk);
    tests++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
      fails++; $display("FAIL rstmid_first: got %b%b want 10", p0_gnt, p1_gnt);
    end
    tick();
    p0_req = 1'b0;
    @(negedge clk);
    tests++; if (p1_gnt !== 1'b1) begin fails++; $display("FAIL rstmid_own: got %b want 1", p1_gnt); end
    tests++; if (p0_rvalid !== 1'b1 || p0_rdata !== ref_mem[5]) begin
      fails++; $display("FAIL rstmid_pre_rdata: got v=%b d=%h want 1 %h", p0_rvalid, p0_rdata, ref_mem[5]);
    end
    tick();
    rst = 1'b1;
    p0_req = 1'b1;
    p1_we = 1'b1; p1_wdata = 32'h0BAD_0BAD;
    @(negedge clk);
    tests++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin
      fails++; $display("FAIL rstmid_gnt: got %b%b want 00", p0_gnt, p1_gnt);
    end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rstmid_we: got %b want 0", mem_we); end
    tick();
    rst = 1'b0;
    p1_we = 1'b0;
    @(negedge clk);
    tests++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
      fails++; $display("FAIL rstmid_rvalid: got %b%b want 00", p0_rvalid, p1_rvalid);
    end
    tests++; if (p0_rdata !== '0 || p1_rdata !== '0) begin
      fails++; $display("FAIL rstmid_rdata: got %h %h want 0 0", p0_rdata, p1_rdata);
    end
    tests++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
      fails++; $display("FAIL rstmid_idle: got %b%b want 10", p0_gnt, p1_gnt);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    tests++; if (p0_rvalid !== 1'b1 || p0_rdata !== ref_mem[5]) begin
      fails++; $display("FAIL rstmid_no_write: got v=%b d=%h want 1 %h", p0_rvalid, p0_rdata, ref_mem[5]);
    end
    tick();
  endtask

  task automatic test_idle_hold();
    do_reset();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 7; p0_wdata = 32'h7777_0007;
    @(negedge clk);
    tests++; if (p0_gnt !== 1'b1) begin fails++; $display("FAIL hold_w0_gnt: got %b want 1", p0_gnt); end
    tick();
    ref_mem[7] = 32'h7777_0007;
    idle_inputs();
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 11; p1_wdata = 32'hBBBB_000B;
    @(negedge clk);
    tests++; if (p1_gnt !== 1'b1) begin fails++; $display("FAIL hold_w1_gnt: got %b want 1", p1_gnt); end
    tick();
    ref_mem[11] = 32'hBBBB_000B;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || mem_we !== 1'b0) begin
        fails++; $display("FAIL hold_idle_%0d: got gnt=%b%b we=%b want 00 0", k, p0_gnt, p1_gnt, mem_we);
      end
      tests++; if (mem_addr !== 32'd11 || mem_wd !== 32'hBBBB_000B) begin
        fails++; $display("FAIL hold_bus_%0d: got addr=%h wd=%h want b bbbb000b", k, mem_addr, mem_wd);
      end
      tick();
    end
  endtask

  task automatic test_random(input int n);
    int owner, cnt, last, g;
    bit forced, exp_we, hold_ok;
    bit pend [2];
    bit req [2];
    bit we [2];
    bit lock [2];
    bit exp_rv [2];
    logic [3:0]        ad [2];
    logic [WIDTH-1:0]  wd [2];
    logic [WIDTH-1:0]  exp_rd [2];
    logic [ADDR_W-1:0] hold_addr;
    logic [WIDTH-1:0]  hold_wd;
    do_reset();
    owner = -1; cnt = 0; last = 1; hold_ok = 1'b0;
    hold_addr = '0; hold_wd = '0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; req[p] = 1'b0; we[p] = 1'b0; lock[p] = 1'b0;
      exp_rv[p] = 1'b0; exp_rd[p] = '0; ad[p] = '0; wd[p] = '0;
    end
    for (int c = 0; c < n; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          req[p]  = ($urandom_range(0, 99) < 55);
          we[p]   = 1'($urandom_range(0, 1));
          ad[p]   = 4'($urandom_range(0, 15));
          wd[p]   = $urandom;
          pend[p] = req[p];
        end
        lock[p] = ($urandom_range(0, 99) < (p == 1 ? 70 : 40));
      end
      p0_req = req[0]; p0_we = we[0]; p0_lock = lock[0]; p0_addr = 32'(ad[0]); p0_wdata = wd[0];
      p1_req = req[1]; p1_we = we[1]; p1_lock = lock[1]; p1_addr = 32'(ad[1]); p1_wdata = wd[1];

      // Expected winner from the ownership / burst / tie rules.
      g = -1;
      if (!rst) begin
        if (owner >= 0 && req[owner]) g = (cnt >= MAX_BURST && req[1 - owner]) ? 1 - owner : owner;
        else if (req[0] && req[1]) g = RR ? 1 - last : 0;
        else if (req[0]) g = 0;
        else if (req[1]) g = 1;
      end
      exp_we = 1'b0;
      if (g >= 0) exp_we = we[g];

      @(negedge clk);
      tests++; if (p0_gnt !== (g == 0) || p1_gnt !== (g == 1)) begin
        fails++; $display("FAIL rnd_gnt c=%0d: got %b%b want winner %0d", c, p0_gnt, p1_gnt, g);
      end
      tests++; if (mem_we !== exp_we) begin
        fails++; $display("FAIL rnd_we c=%0d: got %b want %b", c, mem_we, exp_we);
      end
      if (g >= 0) begin
        tests++; if (mem_addr !== 32'(ad[g]) || mem_wd !== wd[g]) begin
          fails++; $display("FAIL rnd_bus c=%0d: got %h/%h want %h/%h", c, mem_addr, mem_wd, 32'(ad[g]), wd[g]);
        end
      end else if (hold_ok) begin
        tests++; if (mem_addr !== hold_addr || mem_wd !== hold_wd) begin
          fails++; $display("FAIL rnd_hold c=%0d: got %h/%h want %h/%h", c, mem_addr, mem_wd, hold_addr, hold_wd);
        end
      end
      tests++; if (p0_rvalid !== exp_rv[0] || p0_rdata !== exp_rd[0]) begin
        fails++; $display("FAIL rnd_p0_read c=%0d: got %b/%h want %b/%h", c, p0_rvalid, p0_rdata, exp_rv[0], exp_rd[0]);
      end
      tests++; if (p1_rvalid !== exp_rv[1] || p1_rdata !== exp_rd[1]) begin
        fails++; $display("FAIL rnd_p1_read c=%0d: got %b/%h want %b/%h", c, p1_rvalid, p1_rdata, exp_rv[1], exp_rd[1]);
      end

      if (rst) begin
        owner = -1; cnt = 0; last = 1; hold_ok = 1'b0;
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0; exp_rd[0] = '0; exp_rd[1] = '0;
      end else begin
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
        if (g < 0) begin
          owner = -1; cnt = 0;
        end else begin
          forced = (owner >= 0 && owner != g && req[owner]);
          if (we[g]) ref_mem[ad[g]] = wd[g];
          else begin exp_rv[g] = 1'b1; exp_rd[g] = ref_mem[ad[g]]; end
          if (forced || !lock[g]) begin
            owner = -1; cnt = 0;
          end else begin
            cnt   = (owner == g) ? ((cnt + 1 > MAX_BURST) ? MAX_BURST : cnt + 1) : 1;
            owner = g;
          end
          last = g; hold_ok = 1'b1; hold_addr = 32'(ad[g]); hold_wd = wd[g];
          pend[g] = 1'b0;
        end
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_rw();
    test_tie();
    test_burst();
    test_same_addr();
    test_rst_mid();
    test_idle_hold();
    test_random(3000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
